// File: rtl/oci_dct_trace_sequencer.sv
// oci_dct_trace_sequencer
// Packs 2-bit OCI data-compression-trace fragments into a 30-bit DCT buffer
// with a fragment count, offers each full or flushed buffer to the trace sink
// over valid/ready, and sequences the end-of-test drain.
module oci_dct_trace_sequencer #(
  parameter int FRAG_W    = 2,
  parameter int NUM_FRAGS = 15,
  parameter int CNT_W     = 4,
  parameter int WCNT_W    = 16,
  localparam int BUF_W    = FRAG_W * NUM_FRAGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frag_valid,
  input  logic [FRAG_W-1:0] frag_data,
  output logic              frag_ready,
  input  logic              flush,
  input  logic              test_ending,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              test_has_ended,
  output logic [WCNT_W-1:0] words_emitted
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_EMIT  = 2'd1,
    S_ENDED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_FRAGS);

  state_e            state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ending_q, ending_d;
  logic [WCNT_W-1:0] words_q, words_d;
  logic              accept;

  // Ready is decoded from state so the source sees it in the same cycle;
  // it is forced low for the whole time reset is held.
  assign frag_ready = !reset && (state_q == S_FILL) && !ending_q;
  assign accept     = frag_valid && frag_ready;

  // Next-state and datapath decode: fill, hand off, or halt.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    ending_d = ending_q;
    words_d  = words_q;

    // test_ending is sticky from the first cycle it is seen, in any state.
    if (test_ending) ending_d = 1'b1;

    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          buf_d = {buf_q[BUF_W-FRAG_W-1:0], frag_data};
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A fragment accepted alongside flush or test_ending rides in the
        // word being closed; an empty buffer never produces a word.
        if (cnt_d == FULL_CNT || ((ending_d || flush) && cnt_d != '0)) begin
          state_d = S_EMIT;
        end else if (ending_d) begin
          state_d = S_ENDED;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          buf_d   = '0;
          cnt_d   = '0;
          if (words_q != '1) words_d = words_q + WCNT_W'(1);
          state_d = ending_d ? S_ENDED : S_FILL;
        end
      end
      S_ENDED: begin
        state_d = S_ENDED;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State and datapath registers; reset asserts asynchronously so an
  // in-flight word is dropped immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FILL;
      buf_q    <= '0;
      cnt_q    <= '0;
      ending_q <= 1'b0;
      words_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the values
      // from before this edge regardless of statement order.
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      ending_q <= ending_d;
      words_q  <= words_d;
    end
  end

  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign out_valid      = (state_q == S_EMIT);
  assign test_has_ended = (state_q == S_ENDED);
  assign words_emitted  = words_q;

endmodule
